sram_port_arbiter: RTL and testbench

- Shares one single-port SRAM macro (csb0/web0/addr0/din0/dout0, active-low select and write-enable) between two requesters.
  - Port A: the loader/write path.
  - Port B: the read path, i.e. memory readers.
- Round-robin arbitration, with an optional per-port lock so a multi-access sequence (count byte, then payload) is not interleaved.
- Registers all SRAM control signals and returns read data to whichever port issued the read, after a fixed latency.

---
 rtl/sram_arb_pkg.sv | 23 ++
 rtl/sram_port_arbiter_if.sv | 46 ++++
 rtl/rd_tag_pipe.sv | 43 ++++
 rtl/sram_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_sram_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
//   owner_t  : ownership state of the arbiter (lock tracking)
//   rd_tag_t : {valid, port} tag carried alongside an outstanding read
package sram_arb_pkg;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } owner_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // Deepest read latency the tag pipe is expected to cover.
  localparam int unsigned RD_LATENCY_MAX = 4;

  typedef struct packed {
    logic valid;
    logic port;
  } rd_tag_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side bus of the SRAM port arbiter: both ports' request/response
// signals plus the shared busy flag.
//   master : requester side (drives req/we/lock/addr/wdata, sees gnt/rvalid/rdata/busy)
//   slave  : arbiter side
interface sram_port_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
);

  logic                  req_a;
  logic                  we_a;
  logic                  lock_a;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [DATA_WIDTH-1:0] wdata_a;
  logic                  gnt_a;
  logic                  rvalid_a;
  logic [DATA_WIDTH-1:0] rdata_a;

  logic                  req_b;
  logic                  we_b;
  logic                  lock_b;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] wdata_b;
  logic                  gnt_b;
  logic                  rvalid_b;
  logic [DATA_WIDTH-1:0] rdata_b;

  logic                  busy;

  modport master (
    output req_a, we_a, lock_a, addr_a, wdata_a,
    output req_b, we_b, lock_b, addr_b, wdata_b,
    input  gnt_a, rvalid_a, rdata_a,
    input  gnt_b, rvalid_b, rdata_b,
    input  busy
  );

  modport slave (
    input  req_a, we_a, lock_a, addr_a, wdata_a,
    input  req_b, we_b, lock_b, addr_b, wdata_b,
    output gnt_a, rvalid_a, rdata_a,
    output gnt_b, rvalid_b, rdata_b,
    output busy
  );

endinterface

// File: rtl/rd_tag_pipe.sv
// Shift register of {valid, port} tags that tracks outstanding reads so the
// response strobe reaches the port that issued the read.
//   clk, resetn : clock, asynchronous active-low reset (clears every stage)
//   tag_in      : tag entering stage 0
//   tag_out     : tag leaving the last stage
//   any_valid   : some stage holds a valid tag
module rd_tag_pipe
  import sram_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk,
  input  logic    resetn,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out,
  output logic    any_valid
);

  rd_tag_t stage_q [DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= tag_in;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      any_valid = any_valid | stage_q[i].valid;
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM macro between a loader/write port (A) and a
// read port (B). Round-robin grant with optional per-port lock, registered
// SRAM controls, and read data returned to the issuing port RD_LATENCY
// cycles after the handshake edge (legal RD_LATENCY: 1..RD_LATENCY_MAX).
//   clk, resetn        : clock, asynchronous active-low reset
//   bus (slave)        : requester handshake, responses and busy
//   csb0, web0         : SRAM select / write enable, active low, registered
//   addr0, din0        : SRAM address / write data, registered
//   dout0              : SRAM read data
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  sram_port_arbiter_if.slave    bus,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  owner_t owner_q, owner_d;
  logic   last_q, last_d;   // port granted most recently (rr pointer)
  logic   port_q;           // port of the access currently on the SRAM pins

  logic                  want_a, want_b;
  logic                  gnt_a, gnt_b;
  logic                  hs;
  logic                  sel_port;
  logic                  sel_we;
  logic                  sel_lock;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  rd_tag_t tag_in, tag_out;
  logic    any_valid;

  // Grant. Gating with resetn keeps both grants low while reset is held.
  always_comb begin
    want_a = resetn & bus.req_a & (owner_q != OWN_B);
    want_b = resetn & bus.req_b & (owner_q != OWN_A);
    gnt_a  = 1'b0;
    gnt_b  = 1'b0;
    if (want_a && want_b) begin
      if (last_q == PORT_A) begin
        gnt_b = 1'b1;
      end else begin
        gnt_a = 1'b1;
      end
    end else begin
      gnt_a = want_a;
      gnt_b = want_b;
    end
  end

  assign bus.gnt_a = gnt_a;
  assign bus.gnt_b = gnt_b;

  // A grant implies a request, so a grant is a handshake.
  assign hs = gnt_a | gnt_b;

  always_comb begin
    sel_port  = PORT_A;
    sel_we    = bus.we_a;
    sel_lock  = bus.lock_a;
    sel_addr  = bus.addr_a;
    sel_wdata = bus.wdata_a;
    if (gnt_b) begin
      sel_port  = PORT_B;
      sel_we    = bus.we_b;
      sel_lock  = bus.lock_b;
      sel_addr  = bus.addr_b;
      sel_wdata = bus.wdata_b;
    end
  end

  // Owner FSM. A locked handshake by the owner implies lock=1, so release
  // (lock=0) and re-lock can never both hold; the owner simply stays.
  always_comb begin
    owner_d = owner_q;
    last_d  = hs ? sel_port : last_q;
    case (owner_q)
      FREE: begin
        if (hs && sel_lock) begin
          owner_d = gnt_b ? OWN_B : OWN_A;
        end
      end
      OWN_A: begin
        if (!bus.lock_a) begin
          owner_d = FREE;
        end
      end
      OWN_B: begin
        if (!bus.lock_b) begin
          owner_d = FREE;
        end
      end
      default: owner_d = FREE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_q <= FREE;
      last_q  <= PORT_A;
      port_q  <= PORT_A;
      csb0    <= 1'b1;
      web0    <= 1'b1;
      addr0   <= '0;
      din0    <= '0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      if (hs) begin
        csb0   <= 1'b0;
        web0   <= ~sel_we;
        addr0  <= sel_addr;
        din0   <= sel_wdata;
        port_q <= sel_port;
      end else begin
        csb0 <= 1'b1;
        web0 <= 1'b1;
      end
    end
  end

  // The tag enters the pipe from the registered issue stage, so with a pipe
  // of depth RD_LATENCY the strobe lands RD_LATENCY cycles after the
  // handshake edge. Writes push valid=0.
  always_comb begin
    tag_in.valid = ~csb0 & web0;
    tag_in.port  = port_q;
  end

  rd_tag_pipe #(
    .DEPTH(RD_LATENCY)
  ) u_rd_tag_pipe (
    .clk      (clk),
    .resetn   (resetn),
    .tag_in   (tag_in),
    .tag_out  (tag_out),
    .any_valid(any_valid)
  );

  assign bus.rvalid_a = tag_out.valid & (tag_out.port == PORT_A);
  assign bus.rvalid_b = tag_out.valid & (tag_out.port == PORT_B);
  assign bus.rdata_a  = dout0;
  assign bus.rdata_b  = dout0;
  assign bus.busy     = ~csb0 | any_valid;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter. Three DUTs (RD_LATENCY 2, 1, 4) share
// one stimulus; each has its own behavioural SRAM whose read data appears
// RD_LATENCY cycles after the arbiter's handshake edge.
module tb_sram_port_arbiter;

  localparam int unsigned LAT [3] = '{2, 1, 4};

  logic       clk;
  logic       resetn;
  logic       req_a, we_a, lock_a, req_b, we_b, lock_b;
  logic [7:0] addr_a, wdata_a, addr_b, wdata_b;

  logic [2:0] gnt_a_v, gnt_b_v, rv_a_v, rv_b_v, busy_v, csb0_v, web0_v;
  logic [7:0] rd_a_v [3];
  logic [7:0] rd_b_v [3];
  logic [7:0] addr0_v [3];
  logic [7:0] din0_v [3];

  int n_checks;
  int n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int unsigned L = LAT[g];

    sram_port_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) u_if ();

    logic       csb0, web0;
    logic [7:0] addr0, din0, dout0;
    logic [7:0] mem [256];
    logic [7:0] rd_q [L];

    assign u_if.req_a   = req_a;
    assign u_if.we_a    = we_a;
    assign u_if.lock_a  = lock_a;
    assign u_if.addr_a  = addr_a;
    assign u_if.wdata_a = wdata_a;
    assign u_if.req_b   = req_b;
    assign u_if.we_b    = we_b;
    assign u_if.lock_b  = lock_b;
    assign u_if.addr_b  = addr_b;
    assign u_if.wdata_b = wdata_b;

    sram_port_arbiter #(
      .DATA_WIDTH(8),
      .ADDR_WIDTH(8),
      .RD_LATENCY(L)
    ) u_dut (
      .clk   (clk),
      .resetn(resetn),
      .bus   (u_if),
      .csb0  (csb0),
      .web0  (web0),
      .addr0 (addr0),
      .din0  (din0),
      .dout0 (dout0)
    );

    // mem[i] = 0x39 ^ i, so mem[5]=0x3C, mem[1..3]=0x38,0x3B,0x3A, mem[0x10]=0x29.
    initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h39 ^ 8'(i);
    end

    always @(posedge clk) begin
      if (!csb0 && !web0) mem[addr0] <= din0;
      rd_q[0] <= (!csb0 && web0) ? mem[addr0] : 8'h00;
      for (int i = 1; i < int'(L); i++) rd_q[i] <= rd_q[i-1];
    end
    assign dout0 = rd_q[L-1];

    assign gnt_a_v[g] = u_if.gnt_a;
    assign gnt_b_v[g] = u_if.gnt_b;
    assign rv_a_v[g]  = u_if.rvalid_a;
    assign rv_b_v[g]  = u_if.rvalid_b;
    assign busy_v[g]  = u_if.busy;
    assign csb0_v[g]  = csb0;
    assign web0_v[g]  = web0;
    assign rd_a_v[g]  = u_if.rdata_a;
    assign rd_b_v[g]  = u_if.rdata_b;
    assign addr0_v[g] = addr0;
    assign din0_v[g]  = din0;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic r, input logic w, input logic l, input logic [7:0] a,
                       input logic [7:0] d);
    req_a = r; we_a = w; lock_a = l; addr_a = a; wdata_a = d;
  endtask

  task automatic set_b(input logic r, input logic w, input logic l, input logic [7:0] a,
                       input logic [7:0] d);
    req_b = r; we_b = w; lock_b = l; addr_b = a; wdata_b = d;
  endtask

  task automatic idle();
    set_a(0, 0, 0, 8'h00, 8'h00);
    set_b(0, 0, 0, 8'h00, 8'h00);
  endtask

  logic [7:0] pipe_exp [3];
  bit         hit;

  initial begin
    n_checks    = 0;
    n_bad       = 0;
    pipe_exp[0] = 8'h38;
    pipe_exp[1] = 8'h3B;
    pipe_exp[2] = 8'h3A;
    set_a(1, 0, 0, 8'h00, 8'h00);
    set_b(1, 0, 0, 8'h00, 8'h00);
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #2;

    // Reset state, with both requests raised to show grants are held off.
    check_eq("rst_csb0", csb0_v[0], 1);
    check_eq("rst_web0", web0_v[0], 1);
    check_eq("rst_addr0", addr0_v[0], 0);
    check_eq("rst_din0", din0_v[0], 0);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("rst_busy[%0d]", k), busy_v[k], 0);
      check_eq($sformatf("rst_rv[%0d]", k), {rv_a_v[k], rv_b_v[k]}, 0);
      check_eq($sformatf("rst_gnt[%0d]", k), {gnt_a_v[k], gnt_b_v[k]}, 0);
    end
    idle();
    tick();
    tick();
    resetn = 1'b1;

    // Contention: A writes 0x10<=0xAA, B reads 0x10, rr pointer at A.
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i < 4) begin
        set_a(1, 1, 0, 8'h10, 8'hAA);
        set_b(1, 0, 0, 8'h10, 8'h00);
      end else begin
        idle();
      end
      #1;
      if (i < 4) begin
        check_eq($sformatf("cont_gnt_b c%0d", i), gnt_b_v[0], (i % 2 == 0));
        check_eq($sformatf("cont_gnt_a c%0d", i), gnt_a_v[0], (i % 2 == 1));
      end
      if (i == 1) begin
        check_eq("cont_csb0 c1", csb0_v[0], 0);
        check_eq("cont_web0 c1", web0_v[0], 1);
        check_eq("cont_addr0 c1", addr0_v[0], 8'h10);
      end
      if (i == 2) begin
        check_eq("cont_web0 c2", web0_v[0], 0);
        check_eq("cont_din0 c2", din0_v[0], 8'hAA);
      end
      check_eq($sformatf("cont_rv_b c%0d", i), rv_b_v[0], (i == 3 || i == 5));
      check_eq($sformatf("cont_rv_a c%0d", i), rv_a_v[0], 0);
      if (i == 3) check_eq("cont_rdata old", rd_b_v[0], 8'h29);
      if (i == 5) check_eq("cont_rdata new", rd_b_v[0], 8'hAA);
    end

    // Single read of mem[5] on every latency variant.
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 0) set_b(1, 0, 0, 8'h05, 8'h00);
      else idle();
      #1;
      if (i == 0) begin
        for (int k = 0; k < 3; k++) begin
          check_eq($sformatf("sr_gnt_b[%0d]", k), gnt_b_v[k], 1);
          check_eq($sformatf("sr_gnt_a[%0d]", k), gnt_a_v[k], 0);
        end
      end
      if (i == 1) begin
        check_eq("sr_csb0", csb0_v[0], 0);
        check_eq("sr_web0", web0_v[0], 1);
        check_eq("sr_addr0", addr0_v[0], 8'h05);
      end
      if (i >= 1) check_eq($sformatf("sr_busy c%0d", i), busy_v[0], (i <= 3));
      for (int k = 0; k < 3; k++) begin
        hit = (i == 1 + int'(LAT[k]));
        check_eq($sformatf("sr_rv_b[%0d] c%0d", k, i), rv_b_v[k], hit);
        check_eq($sformatf("sr_rv_a[%0d] c%0d", k, i), rv_a_v[k], 0);
        if (hit) check_eq($sformatf("sr_rdata[%0d]", k), rd_b_v[k], 8'h3C);
      end
    end

    // Pipelined reads of 0x01, 0x02, 0x03.
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i < 3) set_b(1, 0, 0, 8'(i + 1), 8'h00);
      else idle();
      #1;
      if (i < 3) check_eq($sformatf("pl_gnt_b c%0d", i), gnt_b_v[0], 1);
      if (i >= 1 && i <= 6) check_eq($sformatf("pl_busy c%0d", i), busy_v[0], (i <= 5));
      for (int k = 0; k < 3; k++) begin
        hit = (i >= 1 + int'(LAT[k])) && (i <= 3 + int'(LAT[k]));
        check_eq($sformatf("pl_rv_b[%0d] c%0d", k, i), rv_b_v[k], hit);
        if (hit) begin
          check_eq($sformatf("pl_rdata[%0d] c%0d", k, i), rd_b_v[k],
                   pipe_exp[i - 1 - int'(LAT[k])]);
        end
      end
    end

    // Lock: A writes 0x00..0x03 locked while B keeps requesting a read of 0x02.
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i < 4) begin
        set_a(1, 1, 1, 8'(i), 8'(8'hD0 + i));
        set_b(1, 0, 0, 8'h02, 8'h00);
      end else if (i < 6) begin
        set_a(0, 0, 0, 8'h00, 8'h00);
        set_b(1, 0, 0, 8'h02, 8'h00);
      end else begin
        idle();
      end
      #1;
      if (i <= 4) check_eq($sformatf("lk_gnt_b c%0d", i), gnt_b_v[0], 0);
      if (i < 4) check_eq($sformatf("lk_gnt_a c%0d", i), gnt_a_v[0], 1);
      if (i == 5) check_eq("lk_gnt_b after release", gnt_b_v[0], 1);
      if (i >= 1 && i <= 4) begin
        check_eq($sformatf("lk_web0 c%0d", i), web0_v[0], 0);
        check_eq($sformatf("lk_addr0 c%0d", i), addr0_v[0], 8'(i - 1));
        check_eq($sformatf("lk_din0 c%0d", i), din0_v[0], 8'(8'hD0 + i - 1));
      end
      check_eq($sformatf("lk_rv_b c%0d", i), rv_b_v[0], (i == 8));
      if (i == 8) check_eq("lk_rdata", rd_b_v[0], 8'hD2);
    end

    // Reset mid-flight: locked read by B, then reset one cycle later.
    tick();
    set_b(1, 0, 1, 8'h05, 8'h00);
    #1;
    check_eq("mr_gnt_b", gnt_b_v[0], 1);
    tick();
    set_b(0, 0, 1, 8'h00, 8'h00);
    set_a(1, 1, 0, 8'h40, 8'h00);
    #1;
    check_eq("mr_csb0 issued", csb0_v[0], 0);
    resetn = 1'b0;
    #1;
    check_eq("mr_csb0 rst", csb0_v[0], 1);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("mr_busy[%0d]", k), busy_v[k], 0);
      check_eq($sformatf("mr_gnt_a[%0d]", k), gnt_a_v[k], 0);
    end
    tick();
    tick();
    resetn = 1'b1;
    #1;
    // lock_b is still high: a grant to A proves ownership was cleared.
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("mr_free gnt_a[%0d]", k), gnt_a_v[k], 1);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      idle();
      #1;
      for (int k = 0; k < 3; k++) begin
        check_eq($sformatf("mr_no_rv[%0d] c%0d", k, i), {rv_a_v[k], rv_b_v[k]}, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
